stmm_layer_sched: RTL
=====================

Name: stmm_layer_sched

Overview:
- Layer scheduler for the StMM wrapper: holds a small table of per-layer descriptors and runs layers back to back.
- Per layer: parameter fetch into weight BRAM, then StMM execution, then feedback capture of Y for the next layer.
- Sits between the NPU control/CSR path and stmm_wrapper.
- Drives start_fetch_param/start_ex and the quantisation parameters, and consumes done_fetch_param/done_ex.

Parameters:
- N_LAYERS, 8, descriptor table depth (max layers per run).
- ADDR_W, 32, SDRAM base-address width.
- TIMEOUT_CYCLES, 65535, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  write descriptor.
- cfg_idx  in  $clog2(N_LAYERS)  descriptor index.
- cfg_base_addr  in  ADDR_W  SDRAM base address of this layer's weights.
- cfg_scale_fp16  in  16  output scale.
- cfg_z_x  in  8  X zero point.
- cfg_z_w  in  8  W zero point.
- cfg_zero  in  8  output zero point.
- run_start  in  1  start a run (pulse).
- run_len  in  $clog2(N_LAYERS)+1  number of layers in the run.
- abort  in  1  cancel the run.
- fetch_start  out  1  pulse to wrapper start_fetch_param.
- fetch_base_addr  out  ADDR_W  base address for the fetcher.
- fetch_done  in  1  from wrapper done_fetch_param.
- ex_start  out  1  pulse to wrapper start_ex.
- ex_done  in  1  from wrapper done_ex.
- scale_fp16  out  16  quantisation parameter to StMM.
- z_x  out  8  quantisation parameter to StMM.
- z_w  out  8  quantisation parameter to StMM.
- zero  out  8  quantisation parameter to StMM.
- x_sel  out  1  X source: 0 = external input, 1 = feedback register.
- y_capture  out  1  load Y_out into the feedback register.
- layer_idx  out  $clog2(N_LAYERS)  current layer.
- busy  out  1  run in progress.
- done  out  1  run complete (one-cycle pulse).
- err_cfg  out  1  illegal run_len (one-cycle pulse).
- err_timeout  out  1  watchdog fired (sticky).

Behaviour:
- Reset (sync, rst=1):
  - State goes to IDLE; descriptor table cleared to 0.
  - All outputs 0. This includes the quantisation outputs, layer_idx and err_timeout.
  - Reset mid-run abandons the run silently: no done, no pulses.
- States: IDLE, FETCH_ISSUE, FETCH_WAIT, EX_ISSUE, EX_WAIT, FINISH, ERR.
- IDLE:
  - cfg_we writes table[cfg_idx] the same edge. Writes with cfg_idx>=N_LAYERS are dropped.
  - run_start with 1<=run_len<=N_LAYERS: layer_idx<=0, clear err_timeout, go to FETCH_ISSUE.
  - run_start with run_len=0 or >N_LAYERS: err_cfg pulses next cycle; stay IDLE.
- FETCH_ISSUE:
  - fetch_start=1 for exactly this cycle.
  - fetch_base_addr=table[layer_idx].base, held until the next FETCH_ISSUE.
  - Next state FETCH_WAIT.
  - Latency: run_start at cycle t gives fetch_start at t+1.
- FETCH_WAIT:
  - Wait for fetch_done=1, then go to EX_ISSUE.
  - fetch_done is sampled only here; a fetch_done arriving in FETCH_ISSUE is ignored.
- EX_ISSUE:
  - ex_start=1 for this cycle.
  - scale_fp16/z_x/z_w/zero load from table[layer_idx] on entry and hold until the next EX_ISSUE or reset.
  - x_sel=(layer_idx!=0), held.
  - Next state EX_WAIT.
  - Latency: fetch_done at cycle u gives ex_start at u+1.
- EX_WAIT:
  - On ex_done=1, y_capture=1 in the same cycle (combinational from state and ex_done).
  - If layer_idx==run_len-1, go to FINISH; else layer_idx++ and go to FETCH_ISSUE.
- FINISH: done=1 for one cycle, then IDLE. The quantisation outputs, x_sel and layer_idx keep their last values.
- busy=1 in every state except IDLE and ERR.
- While busy:
  - run_start, cfg_we and run_len are ignored; the table is locked.
  - ex_done/fetch_done outside their wait states are ignored.
- abort (any non-IDLE state): go to IDLE next cycle; no done; no further pulses. abort has priority over a simultaneous fetch_done/ex_done.
- The run length is latched at run_start; later changes to run_len have no effect.

Optional Feature:
- Macro: STMM_SCHED_TIMEOUT_EN.
- With it:
  - A 16-bit-or-wider wait counter resets on entry to FETCH_WAIT/EX_WAIT and increments each cycle there.
  - Reaching TIMEOUT_CYCLES without the done input moves to ERR and sets err_timeout=1.
  - ERR holds busy=0 and returns to IDLE the next cycle.
  - err_timeout stays set until an accepted run_start or rst.
- Without it: no counter; waits are unbounded; err_timeout tied 0.

Decomposition:
- Package stmm_sched_pkg holds:
  - sched_state_e enum.
  - layer_desc_t packed struct {base_addr, scale_fp16, z_x, z_w, zero}.
  - Localparam QP_W=40.
- One natural sub-module: stmm_desc_table, a register-file table with a write port and one combinational read port indexed by layer_idx.
- The FSM and counters stay in stmm_layer_sched.

Test Plan:
- Single layer: write table[0]={0x1000,0x3C00,3,5,7}; run_start, run_len=1.
  - fetch_start at t+1 with fetch_base_addr=0x1000.
  - fetch_done at t+5 gives ex_start at t+6 with scale=0x3C00, z_x=3, z_w=5, zero=7, x_sel=0.
  - ex_done at t+20 gives y_capture the same cycle; done at t+21.
- Three-layer chain, base 0x1000/0x2000/0x3000:
  - Exactly 3 fetch_start and 3 ex_start pulses, in order.
  - x_sel=0,1,1; layer_idx 0→1→2; single done pulse.
- run_len=0 and run_len=9: err_cfg pulses, busy stays 0, no fetch_start.
- run_start and cfg_we during EX_WAIT: ignored. Table readback unchanged and run proceeds normally.
- Abort or reset mid-op:
  - abort in FETCH_WAIT simultaneous with fetch_done: IDLE next cycle, no ex_start, no done.
  - rst=1 in EX_WAIT: all outputs 0 next cycle.
- STMM_SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=16:
  - Withhold ex_done: err_timeout=1 at cycle 16 of EX_WAIT, busy=0.
  - A new valid run_start clears err_timeout.

Source files
------------

// File: rtl/stmm_sched_pkg.sv
// Shared types for the StMM layer scheduler: FSM states, per-layer descriptor, quant-parameter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stmm_sched_pkg;

   // Width of the base-address field stored per layer; the top's ADDR_W must not exceed it.
   localparam int DESC_ADDR_W = 32;

   // Packed quantisation parameters {scale_fp16, z_x, z_w, zero}.
   localparam int QP_W = 40;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_ISSUE,
      FETCH_WAIT,
      EX_ISSUE,
      EX_WAIT,
      FINISH,
      ERR
   } sched_state_e;

   typedef struct packed {
      logic [DESC_ADDR_W-1:0] base_addr;
      logic [15:0]            scale_fp16;
      logic [7:0]             z_x;
      logic [7:0]             z_w;
      logic [7:0]             zero;
   } layer_desc_t;

   // Extract the quantisation parameters of a descriptor as one vector.
   function automatic logic [QP_W-1:0] desc_qp(input layer_desc_t d);
      return {d.scale_fp16, d.z_x, d.z_w, d.zero};
   endfunction

endpackage

// File: rtl/stmm_desc_table.sv
// Per-layer descriptor register file: one write port, one combinational read port.
// Latency: write lands on the clock edge; read is combinational from rd_idx.
// Backpressure: none; out-of-range writes are dropped, out-of-range reads return zero.
module stmm_desc_table
   import stmm_sched_pkg::*;
#(
   parameter int N_LAYERS = 8,
   parameter int IDX_W    = $clog2(N_LAYERS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  layer_desc_t      wr_desc,
   input  logic [IDX_W-1:0] rd_idx,
   output layer_desc_t      rd_desc
);

   localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(N_LAYERS);

   layer_desc_t mem [N_LAYERS];

   // Table storage: cleared on reset, written only for in-range indices.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_LAYERS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && ({1'b0, wr_idx} < DEPTH)) begin
         mem[wr_idx] <= wr_desc;
      end
   end

   // Read port guarded so a non-power-of-two depth never indexes past the array.
   always_comb begin
      rd_desc = '0;
      if ({1'b0, rd_idx} < DEPTH) begin
         rd_desc = mem[rd_idx];
      end
   end

endmodule

// File: rtl/stmm_layer_sched.sv
// Layer scheduler: per layer issues a parameter fetch, then an StMM execution, then Y feedback capture.
// Latency: run_start -> fetch_start 1 cycle; fetch_done -> ex_start 1 cycle; ex_done -> done 1 cycle.
// Backpressure: waits indefinitely on fetch_done/ex_done; optional watchdog via STMM_SCHED_TIMEOUT_EN.
module stmm_layer_sched
   import stmm_sched_pkg::*;
#(
   parameter int N_LAYERS       = 8,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_we,
   input  logic [$clog2(N_LAYERS)-1:0] cfg_idx,
   input  logic [ADDR_W-1:0]           cfg_base_addr,
   input  logic [15:0]                 cfg_scale_fp16,
   input  logic [7:0]                  cfg_z_x,
   input  logic [7:0]                  cfg_z_w,
   input  logic [7:0]                  cfg_zero,
   input  logic                        run_start,
   input  logic [$clog2(N_LAYERS):0]   run_len,
   input  logic                        abort,
   output logic                        fetch_start,
   output logic [ADDR_W-1:0]           fetch_base_addr,
   input  logic                        fetch_done,
   output logic                        ex_start,
   input  logic                        ex_done,
   output logic [15:0]                 scale_fp16,
   output logic [7:0]                  z_x,
   output logic [7:0]                  z_w,
   output logic [7:0]                  zero,
   output logic                        x_sel,
   output logic                        y_capture,
   output logic [$clog2(N_LAYERS)-1:0] layer_idx,
   output logic                        busy,
   output logic                        done,
   output logic                        err_cfg,
   output logic                        err_timeout
);

   localparam int             IDX_W   = $clog2(N_LAYERS);
   localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(N_LAYERS);

   sched_state_e      state;
   logic [IDX_W-1:0]  run_last;
   logic [IDX_W-1:0]  rd_idx;
   layer_desc_t       rd_desc;
   layer_desc_t       cfg_desc;
   logic              tbl_we;
   logic              len_ok;
   logic [QP_W-1:0]   qp;

`ifdef STMM_SCHED_TIMEOUT_EN
   localparam int                WCNT_W   = ($clog2(TIMEOUT_CYCLES + 1) > 16) ?
                                            $clog2(TIMEOUT_CYCLES + 1) : 16;
   localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
   logic [WCNT_W-1:0]            wait_cnt;
`else
   assign err_timeout = 1'b0;
`endif

   // Table is writable only while idle, so a running schedule never sees its descriptors change.
   assign tbl_we = cfg_we && (state == IDLE);
   assign len_ok = (run_len != '0) && (run_len <= LEN_MAX);

   // Assemble the incoming descriptor; narrower addresses are zero-extended into the table field.
   always_comb begin
      cfg_desc            = '0;
      cfg_desc.base_addr  = DESC_ADDR_W'(cfg_base_addr);
      cfg_desc.scale_fp16 = cfg_scale_fp16;
      cfg_desc.z_x        = cfg_z_x;
      cfg_desc.z_w        = cfg_z_w;
      cfg_desc.zero       = cfg_zero;
   end

   // Read index looks one step ahead so that outputs can be registered on entry to the issue states.
   always_comb begin
      rd_idx = layer_idx;
      if (state == IDLE) begin
         rd_idx = '0;
      end else if (state == EX_WAIT) begin
         rd_idx = layer_idx + 1'b1;
      end
   end

   stmm_desc_table #(
      .N_LAYERS (N_LAYERS),
      .IDX_W    (IDX_W)
   ) u_table (
      .clk     (clk),
      .rst     (rst),
      .we      (tbl_we),
      .wr_idx  (cfg_idx),
      .wr_desc (cfg_desc),
      .rd_idx  (rd_idx),
      .rd_desc (rd_desc)
   );

   assign {scale_fp16, z_x, z_w, zero} = qp;

   // Y is captured in the very cycle ex_done arrives; an abort in that cycle cancels the capture.
   assign y_capture = (state == EX_WAIT) && ex_done && !abort;

   // Scheduler FSM with all control and parameter outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         run_last        <= '0;
         layer_idx       <= '0;
         fetch_start     <= 1'b0;
         fetch_base_addr <= '0;
         ex_start        <= 1'b0;
         qp              <= '0;
         x_sel           <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_cfg         <= 1'b0;
`ifdef STMM_SCHED_TIMEOUT_EN
         wait_cnt        <= '0;
         err_timeout     <= 1'b0;
`endif
      end else begin
         fetch_start <= 1'b0;
         ex_start    <= 1'b0;
         done        <= 1'b0;
         err_cfg     <= 1'b0;
         if (abort && (state != IDLE)) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (run_start) begin
                     if (len_ok) begin
                        layer_idx       <= '0;
                        run_last        <= IDX_W'(run_len - 1'b1);
                        fetch_start     <= 1'b1;
                        fetch_base_addr <= rd_desc.base_addr[ADDR_W-1:0];
                        busy            <= 1'b1;
                        state           <= FETCH_ISSUE;
`ifdef STMM_SCHED_TIMEOUT_EN
                        err_timeout     <= 1'b0;
`endif
                     end else begin
                        err_cfg <= 1'b1;
                     end
                  end
               end
               FETCH_ISSUE: begin
                  state <= FETCH_WAIT;
`ifdef STMM_SCHED_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
               FETCH_WAIT: begin
                  if (fetch_done) begin
                     ex_start <= 1'b1;
                     qp       <= desc_qp(rd_desc);
                     x_sel    <= (layer_idx != '0);
                     state    <= EX_ISSUE;
                  end
`ifdef STMM_SCHED_TIMEOUT_EN
                  else if (wait_cnt == TMO_LAST) begin
                     busy        <= 1'b0;
                     err_timeout <= 1'b1;
                     state       <= ERR;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
`endif
               end
               EX_ISSUE: begin
                  state <= EX_WAIT;
`ifdef STMM_SCHED_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
               EX_WAIT: begin
                  if (ex_done) begin
                     if (layer_idx == run_last) begin
                        done  <= 1'b1;
                        state <= FINISH;
                     end else begin
                        layer_idx       <= layer_idx + 1'b1;
                        fetch_start     <= 1'b1;
                        fetch_base_addr <= rd_desc.base_addr[ADDR_W-1:0];
                        state           <= FETCH_ISSUE;
                     end
                  end
`ifdef STMM_SCHED_TIMEOUT_EN
                  else if (wait_cnt == TMO_LAST) begin
                     busy        <= 1'b0;
                     err_timeout <= 1'b1;
                     state       <= ERR;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
`endif
               end
               FINISH: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               ERR: begin
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
